edge_detector_bank: RTL
=======================

// Module: edge_detector_bank
// PURPOSE
//   Multi-channel successor of the single-bit edge detector. Per channel:
//   - synchronises an asynchronous input;
//   - rejects glitches with a debounce counter;
//   - emits one-cycle rise/fall pulses;
//   - keeps a sticky event flag and a saturating event counter, with per-channel mode select.
//   Sits between raw pads/status lines and the control/CSR logic that polls or counts events.
// PARAMETERS
//   NUM_CH          4   number of independent channels (>=1)
//   SYNC_STAGES     2   synchroniser flops per channel (>=1)
//   DEBOUNCE_CYCLES 4   consecutive cycles a new level must hold before it is accepted (>=1; 1 = no filtering)
//   CNT_W           8   width of each per-channel event counter
// PORTS
//   CLK             in   1              single clock; all logic on posedge
//   RST             in   1              synchronous, active-high reset
//   SAMPLE_IN       in   NUM_CH         raw asynchronous inputs, channel i on bit i
//   MODE            in   2*NUM_CH       per-channel event mode, bits [2i+1:2i]
//   CLEAR           in   NUM_CH         per-channel clear of flag and counter (level, sampled each cycle)
//   LEVEL_OUT       out  NUM_CH         debounced level (stable register)
//   RISE_EDGE_OUT   out  NUM_CH         one-cycle pulse on accepted 0->1
//   FALL_EDGE_OUT   out  NUM_CH         one-cycle pulse on accepted 1->0
//   EVENT_FLAG      out  NUM_CH         sticky: qualified edge seen since last clear
//   EVENT_CNT       out  CNT_W*NUM_CH   saturating count of qualified edges, channel i at [CNT_W*i +: CNT_W]
//   ANY_EVENT       out  1              OR of EVENT_FLAG
// BEHAVIOUR
//   Reset (RST=1 at a posedge): all sync flops, stable levels, debounce counters, pulses, flags and counters go to 0.
//   - All outputs read 0 in the cycle after reset.
//   - A reset asserted mid-debounce discards the partial count.
//   Synchroniser: plain shift chain, SAMPLE_IN -> s[0] -> ... -> s[SYNC_STAGES-1] = sync_i.
//   Debounce, per channel (registers: stable, dcnt):
//   - sync_i == stable: dcnt <= 0.
//   - sync_i != stable and dcnt == DEBOUNCE_CYCLES-1: stable <= sync_i, dcnt <= 0.
//   - otherwise: dcnt <= dcnt+1.
//   - dcnt width is clog2(DEBOUNCE_CYCLES), minimum 1.
//   - A pulse shorter than DEBOUNCE_CYCLES cycles at sync_i never changes stable.
//   Edge pulses are registered on the same edge stable updates:
//   - RISE <= ~stable & stable_next; FALL <= stable & ~stable_next.
//   - Each is high exactly one cycle. Rise and fall are never high together.
//   Latency: SAMPLE_IN changes (meeting setup) before posedge #1 -> LEVEL_OUT and pulse high after posedge #(SYNC_STAGES+DEBOUNCE_CYCLES).
//   MODE encoding: 00 off, 01 rise, 10 fall, 11 both. A qualified edge is a pulse matching MODE.
//   - MODE affects only flag/counter; RISE/FALL/LEVEL outputs are unconditional.
//   - MODE changes take effect the next cycle.
//   Flag/counter update, evaluated on each pulse cycle:
//   - Qualified edge and no CLEAR: flag <= 1; cnt <= cnt+1, saturating at 2^CNT_W-1 (no wrap).
//   - CLEAR only: flag <= 0, cnt <= 0.
//   - CLEAR and qualified edge in the same cycle: flag <= 1, cnt <= 1. The new event is never lost.
//   Power-up and reset-exit behaviour:
//   - Stable resets to 0, so an input already high at reset exit yields one RISE after the latency. This is intended.
//   - Its flag/counter update follows MODE.
//   ANY_EVENT is combinational OR of the registered flags; no extra latency.
// STRUCTURE
//   Shared package edge_pkg:
//   - localparams MODE_OFF=2'b00, MODE_RISE=2'b01, MODE_FALL=2'b10, MODE_BOTH=2'b11;
//   - function clog2 for counter sizing.
//   Sub-module edge_channel:
//   - one channel (sync chain, debounce, pulse, flag, counter), same parameters minus NUM_CH;
//   - instantiated NUM_CH times in a generate loop.
//   Top level does slicing of MODE/EVENT_CNT and the ANY_EVENT reduction only.
// TESTING (defaults NUM_CH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, CNT_W=8)
//   1 Latency: reset, MODE=all 11. Ch0 0->1 before posedge #1 and hold.
//     -> RISE[0] high exactly the cycle after posedge #6; LEVEL_OUT[0]=1 from then.
//     -> EVENT_FLAG[0]=1, EVENT_CNT[0]=1, ANY_EVENT=1.
//   2 Glitch reject: ch1 high for 3 cycles then low.
//     -> no RISE/FALL on ch1, LEVEL_OUT[1]=0, counter stays 0.
//     -> Repeat with 4 cycles high -> one RISE, then one FALL 4 cycles after release.
//   3 Modes: ch2 MODE=01, ch3 MODE=10; drive one full high/low pulse (>=4 cycles each) on both.
//     -> both channels pulse RISE and FALL.
//     -> only ch2 cnt=1 (from rise), only ch3 cnt=1 (from fall); MODE=00 -> cnt stays 0.
//   4 Clear races: CLEAR[0] alone -> flag 0, cnt 0.
//     -> CLEAR[0] in the same cycle as a qualified RISE[0] -> flag 1, cnt 1.
//   5 Saturation: CNT_W=2, 5 qualified edges on ch0 -> cnt reads 1,2,3,3,3.
//   6 Reset mid-operation: assert RST during dcnt=2 of a pending rise, hold 1 cycle, input stays high.
//     -> all outputs 0 after reset.
//     -> RISE fires a full SYNC_STAGES+DEBOUNCE_CYCLES cycles after reset release (no partial credit).

Source files
------------

// File: rtl/edge_detector_bank_pkg.sv
// Shared definitions for the edge detector bank: event-mode encoding and
// counter sizing helpers.
package edge_pkg;

   typedef enum logic [1:0] {
      MODE_OFF  = 2'b00,
      MODE_RISE = 2'b01,
      MODE_FALL = 2'b10,
      MODE_BOTH = 2'b11
   } mode_e;

   // Ceiling log2; returns 0 for v <= 1.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) r = i + 1;
      end
      return r;
   endfunction

   // True when a registered pulse matches the channel's event mode.
   function automatic logic edge_qualifies(input mode_e m, input logic rise, input logic fall);
      logic q;
      q = 1'b0;
      case (m)
         MODE_OFF:  q = 1'b0;
         MODE_RISE: q = rise;
         MODE_FALL: q = fall;
         MODE_BOTH: q = rise | fall;
         default:   q = 1'b0;
      endcase
      return q;
   endfunction

endpackage

// File: rtl/edge_detector_bank_channel.sv
// One channel of the edge detector bank: synchroniser, debounce filter,
// edge pulses, sticky flag and saturating event counter.
module edge_channel
   import edge_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned CNT_W           = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             SAMPLE_IN,
   input  logic [1:0]       MODE,
   input  logic             CLEAR,
   output logic             LEVEL_OUT,
   output logic             RISE_EDGE_OUT,
   output logic             FALL_EDGE_OUT,
   output logic             EVENT_FLAG,
   output logic [CNT_W-1:0] EVENT_CNT
);

   localparam int unsigned DW_RAW = clog2(DEBOUNCE_CYCLES);
   localparam int unsigned DW     = (DW_RAW < 1) ? 1 : DW_RAW;
   localparam logic [DW-1:0]    DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_i;
   logic                   stable_q;
   logic                   stable_next;
   logic [DW-1:0]          dcnt_q;
   logic [DW-1:0]          dcnt_next;
   logic                   rise_q;
   logic                   fall_q;
   logic                   qualified;
   logic                   flag_q;
   logic [CNT_W-1:0]       cnt_q;

   assign sync_i = sync_q[SYNC_STAGES-1];

   always_ff @(posedge CLK) begin
      if (RST) begin
         sync_q <= '0;
      end else begin
         sync_q[0] <= SAMPLE_IN;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   // A new level is accepted only after it has differed from the stable
   // level for DEBOUNCE_CYCLES consecutive cycles.
   always_comb begin
      stable_next = stable_q;
      dcnt_next   = '0;
      if (sync_i != stable_q) begin
         if (dcnt_q == DCNT_LAST) begin
            stable_next = sync_i;
         end else begin
            dcnt_next = dcnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         stable_q <= 1'b0;
         dcnt_q   <= '0;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
      end else begin
         stable_q <= stable_next;
         dcnt_q   <= dcnt_next;
         rise_q   <= ~stable_q & stable_next;
         fall_q   <= stable_q & ~stable_next;
      end
   end

   assign qualified = edge_qualifies(mode_e'(MODE), rise_q, fall_q);

   // A qualified edge coinciding with CLEAR restarts the count at one.
   always_ff @(posedge CLK) begin
      if (RST) begin
         flag_q <= 1'b0;
         cnt_q  <= '0;
      end else if (CLEAR) begin
         flag_q <= qualified;
         cnt_q  <= qualified ? CNT_ONE : '0;
      end else if (qualified) begin
         flag_q <= 1'b1;
         if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
      end
   end

   assign LEVEL_OUT     = stable_q;
   assign RISE_EDGE_OUT = rise_q;
   assign FALL_EDGE_OUT = fall_q;
   assign EVENT_FLAG    = flag_q;
   assign EVENT_CNT     = cnt_q;

endmodule

// File: rtl/edge_detector_bank.sv
// Multi-channel edge detector: one edge_channel per input bit, plus an
// aggregated event indication.
module edge_detector_bank #(
   parameter int unsigned NUM_CH          = 4,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned CNT_W           = 8
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [NUM_CH-1:0]       SAMPLE_IN,
   input  logic [2*NUM_CH-1:0]     MODE,
   input  logic [NUM_CH-1:0]       CLEAR,
   output logic [NUM_CH-1:0]       LEVEL_OUT,
   output logic [NUM_CH-1:0]       RISE_EDGE_OUT,
   output logic [NUM_CH-1:0]       FALL_EDGE_OUT,
   output logic [NUM_CH-1:0]       EVENT_FLAG,
   output logic [CNT_W*NUM_CH-1:0] EVENT_CNT,
   output logic                    ANY_EVENT
);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      edge_channel #(
         .SYNC_STAGES    (SYNC_STAGES),
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .CNT_W          (CNT_W)
      ) u_ch (
         .CLK          (CLK),
         .RST          (RST),
         .SAMPLE_IN    (SAMPLE_IN[i]),
         .MODE         (MODE[2*i +: 2]),
         .CLEAR        (CLEAR[i]),
         .LEVEL_OUT    (LEVEL_OUT[i]),
         .RISE_EDGE_OUT(RISE_EDGE_OUT[i]),
         .FALL_EDGE_OUT(FALL_EDGE_OUT[i]),
         .EVENT_FLAG   (EVENT_FLAG[i]),
         .EVENT_CNT    (EVENT_CNT[CNT_W*i +: CNT_W])
      );
   end

   assign ANY_EVENT = |EVENT_FLAG;

endmodule
